// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: hazard FSM states, register address width,
// decode opcodes, and the load-use hazard test.
package mips_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_e;

   localparam int REG_AW = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   // $zero is never a real producer, so a load into it cannot create a hazard
   function automatic logic loadUse(
      input logic              exMemRead,
      input logic [REG_AW-1:0] exRt,
      input logic [REG_AW-1:0] idRs,
      input logic [REG_AW-1:0] idRt,
      input logic              idUsesRt
   );
      return exMemRead && (exRt != '0) &&
             ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
   endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side signal bundle of the hazard controller: stage fields in, stage controls out.
interface hazard_controller_if;
   import mips_pkg::*;

   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rt;
   logic              ex_memread;
   logic [REG_AW-1:0] ex_rt;
   logic              ex_branch_taken;
   logic              mem_req;
   logic              mem_ready;

   logic              pc_write;
   logic              ifid_write;
   logic              ifid_flush;
   logic              idex_bubble;
   logic              pipe_hold;
   logic              mem_err;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken, mem_req, mem_ready,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_err
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken, mem_req, mem_ready,
      output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_err
   );

endinterface

// File: rtl/hazard_perf_counters.sv
// Saturating stall/flush event counters; outputs read zero while reset is asserted.
module hazard_perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_inc_i,
   input  logic             flush_inc_i,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
   logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

   always_comb begin
      stallCnt_d = stallCnt_q;
      flushCnt_d = flushCnt_q;
      if (stall_inc_i && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + 1'b1;
      if (flush_inc_i && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   assign stall_cnt_o = reset ? '0 : stallCnt_q;
   assign flush_cnt_o = reset ? '0 : flushCnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes, memory-wait holds.
// Define HAZARD_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module hazard_controller
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input logic          clk,
   input logic          reset,
   hazard_controller_if.slave hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT - 1);

   if ((MEM_TIMEOUT < 1) || (CNT_W < 1)) begin : gBadParams
      $error("hazard_controller: MEM_TIMEOUT and CNT_W must be positive");
   end

   hz_state_e       state_q, state_d;
   logic            branchPend_q, branchPend_d;
   logic [TO_W-1:0] toCnt_q, toCnt_d;
   logic            memErr_q, memErr_d;

   logic lu;
   logic pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold;

   assign lu = loadUse(hz.ex_memread, hz.ex_rt, hz.id_rs, hz.id_rt, hz.id_uses_rt);

   // Next state and stage controls; a branch seen while a memory stall starts is replayed on release
   always_comb begin
      state_d      = state_q;
      branchPend_d = branchPend_q;
      toCnt_d      = toCnt_q;
      memErr_d     = memErr_q;
      pcWrite      = 1'b1;
      ifidWrite    = 1'b1;
      ifidFlush    = 1'b0;
      idexBubble   = 1'b0;
      pipeHold     = 1'b0;

      unique case (state_q)
         RUN: begin
            toCnt_d = '0;
            if (hz.mem_req && !hz.mem_ready) begin
               pipeHold     = 1'b1;
               pcWrite      = 1'b0;
               ifidWrite    = 1'b0;
               state_d      = MEM_WAIT;
               branchPend_d = hz.ex_branch_taken;
            end else if (hz.ex_branch_taken) begin
               ifidFlush  = 1'b1;
               idexBubble = 1'b1;
            end else if (lu) begin
               pcWrite    = 1'b0;
               ifidWrite  = 1'b0;
               idexBubble = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (hz.mem_ready) begin
               state_d = RUN;
               toCnt_d = '0;
               if (branchPend_q) begin
                  ifidFlush    = 1'b1;
                  idexBubble   = 1'b1;
                  branchPend_d = 1'b0;
               end
            end else begin
               pipeHold  = 1'b1;
               pcWrite   = 1'b0;
               ifidWrite = 1'b0;
               if (toCnt_q != TO_LIMIT) toCnt_d = toCnt_q + 1'b1;
               if (toCnt_d == TO_LIMIT) memErr_d = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase

      if (reset) begin
         state_d      = RUN;
         branchPend_d = 1'b0;
         toCnt_d      = '0;
         memErr_d     = 1'b0;
         pcWrite      = 1'b1;
         ifidWrite    = 1'b1;
         ifidFlush    = 1'b0;
         idexBubble   = 1'b0;
         pipeHold     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RUN;
         branchPend_q <= 1'b0;
         toCnt_q      <= '0;
         memErr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         branchPend_q <= branchPend_d;
         toCnt_q      <= toCnt_d;
         memErr_q     <= memErr_d;
      end
   end

   assign hz.pc_write    = pcWrite;
   assign hz.ifid_write  = ifidWrite;
   assign hz.ifid_flush  = ifidFlush;
   assign hz.idex_bubble = idexBubble;
   assign hz.pipe_hold   = pipeHold;
   assign hz.mem_err     = memErr_q && !reset;

`ifdef HAZARD_PERF_EN
   hazard_perf_counters #(
      .CNT_W (CNT_W)
   ) uPerf (
      .clk         (clk),
      .reset       (reset),
      .stall_inc_i (!pcWrite),
      .flush_inc_i (ifidFlush),
      .stall_cnt_o (stall_cnt),
      .flush_cnt_o (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed hazard scenarios then random traffic vs an event-level model.
module tb_hazard_controller;
   import mips_pkg::*;

   localparam int TO    = 4;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic clk;
   logic reset;
   logic [CW-1:0] stallCnt;
   logic [CW-1:0] flushCnt;

   int checks = 0;
   int errors = 0;

   // Model view: pipeline either flowing or parked on memory, plus sticky error and event tallies
   bit mWaiting;
   bit mBranchOwed;
   int mWaitCycles;
   bit mErr;
   int mStalls;
   int mFlushes;

   hazard_controller_if hzIf ();

   hazard_controller #(
      .MEM_TIMEOUT (TO),
      .CNT_W       (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hzIf.slave)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt (stallCnt),
      .flush_cnt (flushCnt)
`endif
   );

`ifndef HAZARD_PERF_EN
   assign stallCnt = '0;
   assign flushCnt = '0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs mid-cycle, advance the model past the edge
   task automatic applyStimulus(input bit rst, input int rs, input int rt, input bit usesRt,
                                input bit memRead, input int exRt, input bit br,
                                input bit mreq, input bit mrdy);
      bit hazard, stallMem, flush, stall, bubble;
      reset              = rst;
      hzIf.id_rs           = REG_AW'(rs);
      hzIf.id_rt           = REG_AW'(rt);
      hzIf.id_uses_rt      = usesRt;
      hzIf.ex_memread      = memRead;
      hzIf.ex_rt           = REG_AW'(exRt);
      hzIf.ex_branch_taken = br;
      hzIf.mem_req         = mreq;
      hzIf.mem_ready       = mrdy;
      #3;

      hazard   = memRead && exRt != 0 && (exRt == rs || (usesRt && exRt == rt));
      stallMem = 0; flush = 0; stall = 0; bubble = 0;
      if (!rst) begin
         if (!mWaiting) begin
            if (mreq && !mrdy)  stallMem = 1;
            else if (br)        flush = 1;
            else if (hazard)    begin stall = 1; bubble = 1; end
         end else begin
            if (!mrdy)          stallMem = 1;
            else if (mBranchOwed) flush = 1;
         end
      end
      if (flush) bubble = 1;

      checkOutput("pc_write",    32'(hzIf.pc_write),    32'(!(stallMem || stall)));
      checkOutput("ifid_write",  32'(hzIf.ifid_write),  32'(!(stallMem || stall)));
      checkOutput("ifid_flush",  32'(hzIf.ifid_flush),  32'(flush));
      checkOutput("idex_bubble", 32'(hzIf.idex_bubble), 32'(bubble));
      checkOutput("pipe_hold",   32'(hzIf.pipe_hold),   32'(stallMem));
      checkOutput("mem_err",     32'(hzIf.mem_err),     32'(mErr && !rst));
`ifdef HAZARD_PERF_EN
      checkOutput("stall_cnt",   32'(stallCnt), rst ? 32'd0 : 32'(mStalls));
      checkOutput("flush_cnt",   32'(flushCnt), rst ? 32'd0 : 32'(mFlushes));
`endif

      if (rst) begin
         mWaiting = 0; mBranchOwed = 0; mWaitCycles = 0; mErr = 0; mStalls = 0; mFlushes = 0;
      end else begin
         if ((stallMem || stall) && mStalls < CMAX) mStalls++;
         if (flush && mFlushes < CMAX) mFlushes++;
         if (!mWaiting) begin
            if (mreq && !mrdy) begin
               mWaiting = 1; mBranchOwed = br; mWaitCycles = 0;
            end
         end else if (mrdy) begin
            mWaiting = 0; mBranchOwed = 0;
         end else begin
            mWaitCycles++;
            if (mWaitCycles >= TO - 1) mErr = 1;
         end
      end

      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle(input bit rst);
      applyStimulus(rst, 5, 6, 1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1;
      hzIf.id_rs = '0; hzIf.id_rt = '0; hzIf.id_uses_rt = 0; hzIf.ex_memread = 0;
      hzIf.ex_rt = '0; hzIf.ex_branch_taken = 0; hzIf.mem_req = 0; hzIf.mem_ready = 0;
      mWaiting = 0; mBranchOwed = 0; mWaitCycles = 0; mErr = 0; mStalls = 0; mFlushes = 0;
      #6;

      // lw $2 followed by a consumer of $2: one bubble
      idleCycle(1);
      applyStimulus(0, 2, 7, 1, 1, 2, 0, 0, 0);
      idleCycle(0);
`ifdef HAZARD_PERF_EN
      checkOutput("tp_lu_stall_cnt", 32'(stallCnt), 32'd1);
`endif

      // load into $zero never stalls
      idleCycle(1);
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0);
      checkOutput("tp_zero_pc_write_after", 32'(hzIf.pc_write), 32'd1);

      // rt only matters when the ID instruction reads it
      applyStimulus(0, 4, 3, 0, 1, 3, 0, 0, 0);
      applyStimulus(0, 4, 3, 1, 1, 3, 0, 0, 0);

      // branch overrides a simultaneous load-use
      idleCycle(1);
      applyStimulus(0, 2, 7, 1, 1, 2, 1, 0, 0);
      idleCycle(0);
`ifdef HAZARD_PERF_EN
      checkOutput("tp_branch_flush_cnt", 32'(flushCnt), 32'd1);
`endif

      // four-cycle access: three held cycles then release
      idleCycle(1);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 1, 1);
      idleCycle(0);
`ifdef HAZARD_PERF_EN
      checkOutput("tp_mem_stall_cnt", 32'(stallCnt), 32'd3);
`endif

      // zero-wait access does not stall
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 1, 1);

      // branch during memory stall is flushed only on release
      idleCycle(1);
      applyStimulus(0, 1, 1, 0, 0, 0, 1, 1, 0);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 1, 0, 0, 0, 1, 1, 1);
      idleCycle(0);

      // timeout: error from the fourth waiting cycle, sticky until reset
      idleCycle(1);
      for (int i = 0; i < 7; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 1, 1);
      idleCycle(0);
      checkOutput("tp_err_sticky", 32'(hzIf.mem_err), 32'd1);
      idleCycle(0);
      idleCycle(1);
      checkOutput("tp_err_cleared", 32'(hzIf.mem_err), 32'd0);

      // reset while waiting discards the owed branch
      applyStimulus(0, 1, 1, 0, 0, 0, 1, 1, 0);
      idleCycle(1);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 1, 1);

      // counter saturation
      for (int i = 0; i < CMAX + 3; i++) applyStimulus(0, 1, 1, 0, 0, 0, 1, 0, 0);

      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(0, 49) == 0,
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage MIPS core. Sits beside the decode control unit and drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory stalls. Holds a small FSM so that a branch resolved during a memory stall is not lost.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum number of consecutive MEM_WAIT cycles before mem_err is raised.
- CNT_W, 32: width of the performance counters. Only used when HAZARD_PERF_EN is defined.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  instruction in ID reads rt (R-type, sw, beq).
- ex_memread  in  1  MemRead bit of the ID/EX register.
- ex_rt  in  5  destination rt held in ID/EX.
- ex_branch_taken  in  1  Branch AND zero, resolved in EX.
- mem_req  in  1  EX/MEM holds a lw or sw (MemRead or MemWrite).
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads all-zero control bits.
- pipe_hold  out  1  freezes ID/EX, EX/MEM and MEM/WB.
- mem_err  out  1  sticky flag: memory timeout occurred.
- stall_cnt  out  CNT_W  load-use plus memory stall cycles (HAZARD_PERF_EN only).
- flush_cnt  out  CNT_W  taken-branch flushes (HAZARD_PERF_EN only).

## Operation
- States: RUN and MEM_WAIT.
- Decision signals are combinational from the current state and the inputs. The state, branch_pending, the timeout counter and mem_err are registered.
- Load-use hazard (lu): ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).
- Priority in RUN, highest first: memory stall, branch flush, load-use.
- RUN with mem_req && !mem_ready:
  - pipe_hold=1, pc_write=0, ifid_write=0.
  - Next state is MEM_WAIT.
  - If ex_branch_taken is high in the same cycle, set branch_pending.
- RUN with ex_branch_taken (no memory stall):
  - ifid_flush=1, idex_bubble=1, pc_write=1.
  - The PC mux selects the target. lu is ignored.
- RUN with lu only: pc_write=0, ifid_write=0, idex_bubble=1. This lasts exactly one cycle.
- RUN with no event: pc_write=1, ifid_write=1, every other control 0.
- MEM_WAIT:
  - pipe_hold=1, pc_write=0, ifid_write=0, no flush.
  - On mem_ready: pipe_hold=0 in that cycle and next state is RUN.
  - If branch_pending is set, in the same release cycle: ifid_flush=1, idex_bubble=1, pc_write=1; branch_pending clears.
- Timeout counter:
  - Increments each cycle spent in MEM_WAIT and resets to 0 on entering RUN.
  - When it reaches MEM_TIMEOUT-1 with mem_ready low, mem_err sets and stays set until reset.
  - The FSM keeps waiting; mem_err does not force a release.
- ex_rt == 0 never causes a stall.

## Timing
- Reset values: state=RUN, branch_pending=0, timeout counter=0, mem_err=0, counters=0.
- Output values while reset is asserted: pc_write=1, ifid_write=1, all other outputs 0.
- Load-use penalty is 1 cycle. Taken-branch penalty is 2 flushed slots with 0 extra cycles.
- A memory access taking N cycles holds the pipe for N-1 cycles. mem_ready in the first cycle gives 0 stall.
- Reset asserted in MEM_WAIT returns to RUN on the next edge and discards branch_pending.
- ex_branch_taken is only sampled in RUN. Inside MEM_WAIT the EX contents are frozen, so it is don't-care.

## Configuration
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments on every cycle with pc_write=0.
  - flush_cnt increments on every cycle with ifid_flush=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: the stall_cnt and flush_cnt ports and their logic are absent.

## Structure
- Shared package (mips_pkg):
  - state enum {RUN, MEM_WAIT}.
  - REG_AW=5.
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, shared with the decode control unit.
- One sub-module: hazard_perf_counters, containing the saturating counters. It is instantiated only under HAZARD_PERF_EN.

## Test plan
- lw $2 in EX (ex_memread=1, ex_rt=2), add with rs=2 in ID -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1, then normal flow; stall_cnt=1.
- Same sequence with ex_rt=0 -> no stall.
- ex_branch_taken=1 with lu also true -> ifid_flush=1, idex_bubble=1, pc_write=1 for one cycle; flush_cnt=1.
- mem_req=1, mem_ready low for 3 cycles then high -> pipe_hold high for 3 cycles, released on the ready cycle; stall_cnt=3.
- mem_req stall coinciding with ex_branch_taken=1 -> flush asserted in the mem_ready release cycle, not before.
- MEM_TIMEOUT=4, mem_ready held low for 6 cycles -> mem_err=1 from the 4th MEM_WAIT cycle. It stays 1 after mem_ready and clears only on reset.
